// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer commit path: instruction kinds, commit word
// layout and the commit FSM state encoding.
package rob_pkg;

  localparam int COMMIT_W        = 79;
  localparam int ARCH_LSB        = 70;
  localparam int ARCH_W          = 5;
  localparam int FLAGS_VALID_BIT = 69;
  localparam int VALUE_VALID_BIT = 68;
  localparam int MISPREDICT_FLAG = 0;

  typedef enum logic [3:0] {
    INST_NOP    = 4'd0,
    INST_ALU    = 4'd1,
    INST_LOAD   = 4'd2,
    INST_STORE  = 4'd3,
    INST_BRANCH = 4'd4
  } inst_t;

  typedef struct packed {
    logic [3:0]  inst_type;
    logic [4:0]  arch_reg;
    logic        flags_valid;
    logic        value_valid;
    logic [3:0]  flags;
    logic [63:0] value;
  } commit_word_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STORE_WAIT,
    ST_FLUSH
  } commit_state_t;

  function automatic logic is_writeback(input logic [3:0] inst_type);
    return (inst_type == INST_ALU) || (inst_type == INST_LOAD);
  endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer; a flush empties it in one edge.
module rob_ptr_ctrl #(
  parameter int ROBsize  = 16,
  parameter int addrSize = $clog2(ROBsize)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                alloc,
  input  logic                retire,
  input  logic                flush,
  output logic [addrSize-1:0] head,
  output logic [addrSize-1:0] tail,
  output logic [addrSize:0]   count
);

  // Pointers wrap naturally because ROBsize is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc)  tail <= tail + addrSize'(1);
      if (retire) head <= head + addrSize'(1);
      case ({alloc, retire})
        2'b10:   count <= count + (addrSize+1)'(1);
        2'b01:   count <= count - (addrSize+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder buffer control: grants tags to decode and retires the head entry in order
// (register writeback, store handshake or mispredict flush), clearing retired entries.
module rob_commit_ctrl
  import rob_pkg::*;
#(
  parameter int ROBsize  = 16,
  parameter int addrSize = $clog2(ROBsize)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  alloc_req_i,
  output logic                  alloc_gnt_o,
  output logic [addrSize-1:0]   alloc_tag_o,
  output logic [addrSize-1:0]   commitReadAddr_o,
  input  logic [COMMIT_W-1:0]   commitReadData_i,
  input  logic [63:0]           commitExtra_i,
  output logic [ROBsize-1:0]    resets_o,
  output logic                  archWriteEn_o,
  output logic [ARCH_W-1:0]     archWriteAddr_o,
  output logic [63:0]           archWriteData_o,
  output logic                  memWriteValid_o,
  input  logic                  memWriteReady_i,
  output logic [63:0]           memWriteAddr_o,
  output logic [63:0]           memWriteData_o,
  output logic                  redirect_o,
  output logic [addrSize:0]     robCount_o,
  output logic                  robEmpty_o
);

  localparam logic [addrSize:0] FULL = (addrSize+1)'(ROBsize);

  commit_word_t          cw;
  commit_state_t         state, state_next;
  logic [addrSize-1:0]   head, tail;
  logic [addrSize:0]     count;
  logic                  head_ready;
  logic                  retire;
  logic                  flush;
  logic                  unused_fields;

  assign cw = commitReadData_i;
  // Fields decoded by bit position below are also visible in the struct view.
  assign unused_fields = ^{cw.arch_reg, cw.flags_valid, cw.value_valid, cw.flags[3:1]};

  rob_ptr_ctrl #(
    .ROBsize  (ROBsize),
    .addrSize (addrSize)
  ) u_ptr (
    .clk     (clk_i),
    .reset_n (reset_n_i),
    .alloc   (alloc_gnt_o),
    .retire  (retire),
    .flush   (flush),
    .head    (head),
    .tail    (tail),
    .count   (count)
  );

  assign head_ready = (count != '0) && commitReadData_i[VALUE_VALID_BIT] &&
                      ((cw.inst_type != INST_BRANCH) || commitReadData_i[FLAGS_VALID_BIT]);

  assign alloc_tag_o      = tail;
  assign commitReadAddr_o = head;
  assign robCount_o       = count;
  assign robEmpty_o       = (count == '0);
  assign archWriteAddr_o  = commitReadData_i[ARCH_LSB +: ARCH_W];
  assign archWriteData_o  = cw.value;
  assign memWriteAddr_o   = commitExtra_i;
  assign memWriteData_o   = cw.value;

  always_comb begin
    state_next      = state;
    retire          = 1'b0;
    flush           = 1'b0;
    archWriteEn_o   = 1'b0;
    memWriteValid_o = 1'b0;
    redirect_o      = 1'b0;
    resets_o        = '0;
    alloc_gnt_o     = reset_n_i && alloc_req_i && (count != FULL) && (state == ST_RUN);
    if (!reset_n_i) begin
      resets_o = '1;
    end else begin
      case (state)
        ST_FLUSH: begin
          resets_o   = '1;
          redirect_o = 1'b1;
          flush      = 1'b1;
          state_next = ST_RUN;
        end
        ST_STORE_WAIT: begin
          // Array entry is held by the stalled head, so address/data stay stable.
          memWriteValid_o = 1'b1;
          if (memWriteReady_i) begin
            retire     = 1'b1;
            state_next = ST_RUN;
          end
        end
        default: begin
          if (head_ready) begin
            if (is_writeback(cw.inst_type)) begin
              archWriteEn_o = 1'b1;
              retire        = 1'b1;
            end else if (cw.inst_type == INST_STORE) begin
              memWriteValid_o = 1'b1;
              if (memWriteReady_i) retire = 1'b1;
              else                 state_next = ST_STORE_WAIT;
            end else if (cw.inst_type == INST_BRANCH) begin
              retire = 1'b1;
              if (cw.flags[MISPREDICT_FLAG]) state_next = ST_FLUSH;
            end else begin
              retire = 1'b1;
            end
          end
        end
      endcase
      if (retire) resets_o[head] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state <= ST_RUN;
    else            state <= state_next;
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: the bench plays the entry array and keeps a queue-level
// model of the buffer; outputs are compared on every falling edge.
module tb_rob_commit_ctrl;

  localparam int N = 16;
  localparam int S_RUN = 0, S_WAIT = 1, S_FLUSH = 2;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          alloc_req_i = 1'b0;
  logic          memWriteReady_i = 1'b0;
  logic [78:0]   commitReadData_i = '0;
  logic [63:0]   commitExtra_i = '0;
  logic          alloc_gnt_o;
  logic [3:0]    alloc_tag_o;
  logic [3:0]    commitReadAddr_o;
  logic [N-1:0]  resets_o;
  logic          archWriteEn_o;
  logic [4:0]    archWriteAddr_o;
  logic [63:0]   archWriteData_o;
  logic          memWriteValid_o;
  logic [63:0]   memWriteAddr_o;
  logic [63:0]   memWriteData_o;
  logic          redirect_o;
  logic [4:0]    robCount_o;
  logic          robEmpty_o;

  rob_commit_ctrl #(.ROBsize(N)) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n_i),
    .alloc_req_i      (alloc_req_i),
    .alloc_gnt_o      (alloc_gnt_o),
    .alloc_tag_o      (alloc_tag_o),
    .commitReadAddr_o (commitReadAddr_o),
    .commitReadData_i (commitReadData_i),
    .commitExtra_i    (commitExtra_i),
    .resets_o         (resets_o),
    .archWriteEn_o    (archWriteEn_o),
    .archWriteAddr_o  (archWriteAddr_o),
    .archWriteData_o  (archWriteData_o),
    .memWriteValid_o  (memWriteValid_o),
    .memWriteReady_i  (memWriteReady_i),
    .memWriteAddr_o   (memWriteAddr_o),
    .memWriteData_o   (memWriteData_o),
    .redirect_o       (redirect_o),
    .robCount_o       (robCount_o),
    .robEmpty_o       (robEmpty_o)
  );

  always #5 clk = ~clk;

  // Entry array contents, one slot per tag
  int          type_a [N];
  int          arch_a [N];
  bit          fv_a   [N];
  bit          vv_a   [N];
  logic [3:0]  flags_a[N];
  logic [63:0] val_a  [N];
  logic [63:0] ext_a  [N];

  int m_head, m_tail, m_count, m_state;
  bit synced = 1'b0;

  // Entry decode will write when the next grant happens
  int p_type, p_arch;
  bit p_fv, p_vv;
  logic [3:0]  p_flags;
  logic [63:0] p_val, p_ext;
  // Snapshot of the entry actually granted this cycle
  int w_type, w_arch;
  bit w_fv, w_vv;
  logic [3:0]  w_flags;
  logic [63:0] w_val, w_ext;

  bit e_gnt, e_we, e_mv, e_red, e_ret;
  logic [N-1:0] e_resets;
  int e_next;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_entry(input int i);
    type_a[i] = 0; arch_a[i] = 0; fv_a[i] = 0; vv_a[i] = 0;
    flags_a[i] = '0; val_a[i] = '0; ext_a[i] = '0;
  endtask

  task automatic pend(input int t, input int a, input logic [63:0] v, input logic [63:0] x,
                      input bit vv, input bit fv, input logic [3:0] f);
    p_type = t; p_arch = a; p_val = v; p_ext = x; p_vv = vv; p_fv = fv; p_flags = f;
  endtask

  task automatic set_valid(input int i);
    vv_a[i] = 1'b1;
    fv_a[i] = 1'b1;
  endtask

  task automatic update_model();
    if (!reset_n_i) begin
      m_head = 0; m_tail = 0; m_count = 0; m_state = S_RUN;
      for (int i = 0; i < N; i++) clear_entry(i);
      synced = 1'b1;
    end else if (synced) begin
      if (m_state == S_FLUSH) begin
        m_head = 0; m_tail = 0; m_count = 0;
        for (int i = 0; i < N; i++) clear_entry(i);
      end else begin
        if (e_ret) begin
          clear_entry(m_head);
          m_head = (m_head + 1) % N;
          m_count--;
        end
        if (e_gnt) begin
          type_a[m_tail] = w_type; arch_a[m_tail] = w_arch; fv_a[m_tail] = w_fv;
          vv_a[m_tail] = w_vv; flags_a[m_tail] = w_flags; val_a[m_tail] = w_val;
          ext_a[m_tail] = w_ext;
          m_tail = (m_tail + 1) % N;
          m_count++;
        end
      end
      m_state = e_next;
    end
  endtask

  task automatic compute_exp();
    int t;
    bit ready;
    e_gnt = 0; e_we = 0; e_mv = 0; e_red = 0; e_ret = 0; e_resets = '0; e_next = m_state;
    t = type_a[m_head];
    if (!reset_n_i) begin
      e_resets = '1;
      e_next = S_RUN;
    end else if (m_state == S_FLUSH) begin
      e_resets = '1; e_red = 1; e_next = S_RUN;
    end else if (m_state == S_WAIT) begin
      e_mv = 1;
      if (memWriteReady_i) begin e_ret = 1; e_next = S_RUN; end
    end else begin
      e_gnt = alloc_req_i && (m_count < N);
      ready = (m_count > 0) && vv_a[m_head] && (t != 4 || fv_a[m_head]);
      if (ready) begin
        case (t)
          1, 2: begin e_we = 1; e_ret = 1; end
          3: begin
            e_mv = 1;
            if (memWriteReady_i) e_ret = 1;
            else e_next = S_WAIT;
          end
          4: begin
            e_ret = 1;
            if (flags_a[m_head][0]) e_next = S_FLUSH;
          end
          default: e_ret = 1;
        endcase
      end
    end
    if (e_ret) e_resets[m_head] = 1'b1;
    w_type = p_type; w_arch = p_arch; w_fv = p_fv; w_vv = p_vv;
    w_flags = p_flags; w_val = p_val; w_ext = p_ext;
  endtask

  task automatic compare_all();
    chk("gnt", alloc_gnt_o, e_gnt);
    chk("tag", alloc_tag_o, m_tail);
    chk("raddr", commitReadAddr_o, m_head);
    chk("count", robCount_o, m_count);
    chk("empty", robEmpty_o, m_count == 0);
    chk("resets", resets_o, e_resets);
    chk("awe", archWriteEn_o, e_we);
    if (e_we) begin
      chk("awaddr", archWriteAddr_o, arch_a[m_head]);
      chk("awdata", archWriteData_o, val_a[m_head]);
    end
    chk("mvalid", memWriteValid_o, e_mv);
    if (e_mv) begin
      chk("maddr", memWriteAddr_o, ext_a[m_head]);
      chk("mdata", memWriteData_o, val_a[m_head]);
    end
    chk("redirect", redirect_o, e_red);
  endtask

  task automatic step(input bit req, input bit rdy, input bit rstn);
    @(posedge clk);
    update_model();
    #1;
    cyc++;
    alloc_req_i = req;
    memWriteReady_i = rdy;
    reset_n_i = rstn;
    commitReadData_i = {4'(type_a[m_head]), 5'(arch_a[m_head]), fv_a[m_head], vv_a[m_head],
                        flags_a[m_head], val_a[m_head]};
    commitExtra_i = ext_a[m_head];
    @(negedge clk);
    compute_exp();
    if (synced) compare_all();
  endtask

  task automatic rand_pend();
    int t;
    t = $urandom_range(0, 9);
    if (t > 8)      p_type = $urandom_range(5, 15);
    else if (t > 4) p_type = 1;
    else            p_type = t;
    p_arch  = $urandom_range(0, 31);
    p_val   = {$urandom, $urandom};
    p_ext   = {$urandom, $urandom};
    p_vv    = $urandom_range(0, 1);
    p_fv    = $urandom_range(0, 1);
    p_flags = {3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) clear_entry(i);
    pend(0, 0, '0, '0, 0, 0, '0);

    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_resets", resets_o, 16'hFFFF);
    chk("rst_empty", robEmpty_o, 1);

    // Three grants, then ALU writeback of entry 0
    pend(1, 5, 64'h1234, '0, 0, 0, '0);
    step(1, 0, 1); chk("t1_tag0", alloc_tag_o, 0); chk("t1_gnt", alloc_gnt_o, 1);
    pend(0, 0, '0, '0, 0, 0, '0);
    step(1, 0, 1); chk("t1_tag1", alloc_tag_o, 1);
    step(1, 0, 1); chk("t1_tag2", alloc_tag_o, 2);
    step(0, 0, 1); chk("t1_cnt3", robCount_o, 3);
    set_valid(0);
    step(0, 0, 1);
    chk("t1_awe", archWriteEn_o, 1); chk("t1_awaddr", archWriteAddr_o, 5);
    chk("t1_awdata", archWriteData_o, 64'h1234); chk("t1_resets", resets_o, 16'h0001);
    step(0, 0, 1); chk("t1_cnt2", robCount_o, 2); chk("t1_awe_off", archWriteEn_o, 0);

    // Fill to 16, refuse the 17th, then retire and allocate across the wrap
    step(0, 0, 0);
    for (int i = 0; i < N; i++) begin
      pend(0, 0, '0, '0, 0, 0, '0);
      step(1, 0, 1); chk("t2_tag", alloc_tag_o, i);
    end
    step(1, 0, 1);
    chk("t2_full_gnt", alloc_gnt_o, 0); chk("t2_cnt16", robCount_o, 16); chk("t2_tagwrap", alloc_tag_o, 0);
    set_valid(0);
    step(0, 0, 1); chk("t2_ret0", resets_o, 16'h0001);
    set_valid(1);
    step(1, 0, 1);
    chk("t2_gnt_ret", alloc_gnt_o, 1); chk("t2_tag0", alloc_tag_o, 0);
    chk("t2_cnt15", robCount_o, 15); chk("t2_ret1", resets_o, 16'h0002);
    step(0, 0, 1); chk("t2_cnt_same", robCount_o, 15); chk("t2_tag1", alloc_tag_o, 1);

    // Store held for three not-ready cycles
    step(0, 0, 0);
    pend(3, 0, 64'hAB, 64'h80, 1, 0, '0);
    step(1, 0, 1);
    pend(0, 0, '0, '0, 0, 0, '0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1);
      chk("t3_mv", memWriteValid_o, 1); chk("t3_maddr", memWriteAddr_o, 64'h80);
      chk("t3_mdata", memWriteData_o, 64'hAB); chk("t3_noreset", resets_o, 16'h0000);
    end
    step(0, 1, 1);
    chk("t3_mv_last", memWriteValid_o, 1); chk("t3_maddr_last", memWriteAddr_o, 64'h80);
    chk("t3_reset_head", resets_o, 16'h0001);
    step(0, 0, 1); chk("t3_mv_off", memWriteValid_o, 0); chk("t3_cnt0", robCount_o, 0);

    // Mispredicted branch at entry 2 with entries 3..6 behind it
    step(0, 0, 0);
    pend(0, 0, '0, '0, 1, 0, '0); step(1, 0, 1);
    step(1, 0, 1);
    pend(4, 0, '0, '0, 0, 1, 4'b0001); step(1, 0, 1);
    pend(1, 3, 64'h55, '0, 0, 0, '0);
    for (int k = 3; k <= 6; k++) step(1, 0, 1);
    step(0, 0, 1); chk("t4_cnt5", robCount_o, 5); chk("t4_head2", commitReadAddr_o, 2);
    set_valid(2);
    step(1, 0, 1); chk("t4_br_reset", resets_o, 16'h0004); chk("t4_br_redir", redirect_o, 0);
    step(1, 0, 1);
    chk("t4_fl_resets", resets_o, 16'hFFFF); chk("t4_fl_redir", redirect_o, 1);
    chk("t4_fl_gnt", alloc_gnt_o, 0);
    step(1, 0, 1); chk("t4_cnt0", robCount_o, 0); chk("t4_tag0", alloc_tag_o, 0);
    chk("t4_gnt", alloc_gnt_o, 1);

    // Head waits on valueValid
    step(0, 0, 0);
    pend(2, 9, 64'hDEAD, '0, 0, 0, '0);
    step(1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1);
      chk("t5_awe", archWriteEn_o, 0); chk("t5_resets", resets_o, 16'h0000);
      chk("t5_head", commitReadAddr_o, 0);
    end
    set_valid(0);
    step(0, 0, 1); chk("t5_awe_on", archWriteEn_o, 1); chk("t5_awaddr", archWriteAddr_o, 9);

    // Reset while a store waits
    step(0, 0, 0);
    pend(3, 0, 64'h77, 64'h100, 1, 0, '0);
    step(1, 0, 1);
    pend(0, 0, '0, '0, 0, 0, '0);
    step(0, 0, 1);
    step(0, 0, 1); chk("t6_mv_wait", memWriteValid_o, 1);
    step(0, 0, 0); chk("t6_mv_drop", memWriteValid_o, 0); chk("t6_resets", resets_o, 16'hFFFF);
    step(1, 0, 1); chk("t6_empty", robEmpty_o, 1); chk("t6_run_gnt", alloc_gnt_o, 1);
    step(0, 1, 1); chk("t6_no_retry", memWriteValid_o, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_pend();
      if ($urandom_range(0, 99) < 30) set_valid($urandom_range(0, N - 1));
      step($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1, $urandom_range(0, 199) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
